// File: rtl/vreg_pkg.sv
// -----------------------------------------------------------------------------
// vreg_pkg
// Shared constants and helpers for the vector register file.
//   VREG_NUM   : number of architectural vector registers
//   VREG_AW    : register index width
//   be_width() : number of byte enables for a VLEN-bit register
// -----------------------------------------------------------------------------
package vreg_pkg;

    localparam int VREG_NUM = 32;
    localparam int VREG_AW  = 5;

    // One byte enable per 8 data bits.
    function automatic int be_width(input int vlen);
        return vlen / 8;
    endfunction

endpackage : vreg_pkg

// File: rtl/vreg_scoreboard.sv
// -----------------------------------------------------------------------------
// vreg_scoreboard
// Per-register pending flags for the vector register file. Issue marks a
// destination busy; the final writeback of an instruction clears it.
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (clears every flag)
//   busy_set  in   mark busy_addr pending
//   busy_addr in   register to mark
//   clr_en    in   clear clr_addr (final write seen)
//   clr_addr  in   register to clear
//   busy      out  32 pending flags, registered
// A set and a clear to the same index on one edge leave the flag set, since
// the set belongs to a younger instruction than the write being retired.
// -----------------------------------------------------------------------------
module vreg_scoreboard
    import vreg_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                busy_set,
    input  logic [VREG_AW-1:0]  busy_addr,
    input  logic                clr_en,
    input  logic [VREG_AW-1:0]  clr_addr,
    output logic [VREG_NUM-1:0] busy
);

    logic [VREG_NUM-1:0] busy_q;
    logic [VREG_NUM-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        // Applied after the clear so it wins on an index collision.
        if (busy_set) begin
            busy_d[busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule : vreg_scoreboard

// File: rtl/vreg_file.sv
// -----------------------------------------------------------------------------
// vreg_file
// Vector register file: 32 registers of VLEN bits, NRD registered read ports,
// one byte-enabled write port, and a per-register busy scoreboard.
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (storage, read data, busy)
//   rd_en      in   per-port read strobe
//   rd_addr    in   per-port index, port p at [5p+4:5p]
//   rd_data    out  per-port registered data, port p at [VLEN*p +: VLEN]
//   wr_en      in   write strobe
//   wr_addr    in   write index (register 0 is ordinary storage)
//   wr_data    in   write data
//   wr_be      in   byte enables, bit b covers wr_data[8b+7:8b]
//   wr_last    in   final write of the instruction, clears busy[wr_addr]
//   busy_set   in   mark busy_addr pending
//   busy_addr  in   register to mark
//   busy       out  per-register pending flags
//   v0_mask    out  combinational copy of register 0
// Build option:
//   VREG_BYPASS_EN - a read colliding with a same-edge write to the same index
//                    returns the merged (post-write) value; without it the
//                    read returns the pre-write stored value.
// -----------------------------------------------------------------------------
module vreg_file #(
    parameter int VLEN = 128,
    parameter int NRD  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*5-1:0]     rd_addr,
    output logic [NRD*VLEN-1:0]  rd_data,
    input  logic                 wr_en,
    input  logic [4:0]           wr_addr,
    input  logic [VLEN-1:0]      wr_data,
    input  logic [VLEN/8-1:0]    wr_be,
    input  logic                 wr_last,
    input  logic                 busy_set,
    input  logic [4:0]           busy_addr,
    output logic [31:0]          busy,
    output logic [VLEN-1:0]      v0_mask
);

    import vreg_pkg::*;

    localparam int BEW = be_width(VLEN);

    // Storage is reset as a whole, so it lives in flops rather than RAM.
    logic [VLEN-1:0] mem_q [VREG_NUM];
    logic [VLEN-1:0] mem_d [VREG_NUM];

    // Current contents of the write target and the byte-merged new value.
    logic [VLEN-1:0] wr_old;
    logic [VLEN-1:0] wr_merged;

    assign wr_old = mem_q[wr_addr];

    genvar gi;
    generate
        for (gi = 0; gi < BEW; gi++) begin : g_merge
            assign wr_merged[8*gi +: 8] = wr_be[gi] ? wr_data[8*gi +: 8]
                                                    : wr_old[8*gi +: 8];
        end
    endgenerate

    // With all byte enables low the merged value equals the old value, so
    // such a write leaves storage untouched without a special case.
    always_comb begin
        for (int i = 0; i < VREG_NUM; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[wr_addr] = wr_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VREG_NUM; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < VREG_NUM; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read ports: capture on rd_en, otherwise hold.
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [VREG_AW-1:0] addr_p;
            logic [VLEN-1:0]    rd_data_q;
            logic [VLEN-1:0]    rd_data_d;

            assign addr_p = rd_addr[5*gi +: 5];

            always_comb begin
                rd_data_d = rd_data_q;
                if (rd_en[gi]) begin
                    rd_data_d = mem_q[addr_p];
`ifdef VREG_BYPASS_EN
                    // Same index as the write means wr_merged was built from
                    // this very register, so it is the forwarded value.
                    if (wr_en && (wr_addr == addr_p)) begin
                        rd_data_d = wr_merged;
                    end
`endif
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q <= '0;
                end else begin
                    rd_data_q <= rd_data_d;
                end
            end

            assign rd_data[VLEN*gi +: VLEN] = rd_data_q;
        end
    endgenerate

    assign v0_mask = mem_q[0];

    vreg_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .clr_en    (wr_en & wr_last),
        .clr_addr  (wr_addr),
        .busy      (busy)
    );

endmodule : vreg_file

// File: tb/tb_vreg_file.sv
// -----------------------------------------------------------------------------
// tb_vreg_file
// Directed bench for vreg_file (VLEN=128, NRD=3). Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point, i.e. after the
// edge that produced them has settled. Follows VREG_BYPASS_EN for the
// collision expectation.
// -----------------------------------------------------------------------------
module tb_vreg_file;

    localparam int VLEN = 128;
    localparam int NRD  = 3;
    localparam int BEW  = VLEN / 8;

    logic                clk;
    logic                rst;
    logic [NRD-1:0]      rd_en;
    logic [NRD*5-1:0]    rd_addr;
    logic [NRD*VLEN-1:0] rd_data;
    logic                wr_en;
    logic [4:0]          wr_addr;
    logic [VLEN-1:0]     wr_data;
    logic [BEW-1:0]      wr_be;
    logic                wr_last;
    logic                busy_set;
    logic [4:0]          busy_addr;
    logic [31:0]         busy;
    logic [VLEN-1:0]     v0_mask;

    int n_checks = 0;
    int n_fail   = 0;

    vreg_file #(.VLEN(VLEN), .NRD(NRD)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .wr_last   (wr_last),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .busy      (busy),
        .v0_mask   (v0_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VLEN-1:0] obs,
                         input logic [VLEN-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    function automatic logic [VLEN-1:0] port(input int p);
        return rd_data[VLEN*p +: VLEN];
    endfunction

    // Advance one edge; inputs set before the call are sampled on it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en     = '0;
        wr_en     = 1'b0;
        wr_last   = 1'b0;
        wr_be     = '0;
        busy_set  = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [VLEN-1:0] d,
                            input logic [BEW-1:0] be, input logic last);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        wr_last = last;
        tick();
        idle();
    endtask

    logic [VLEN-1:0] exp_v;

    initial begin
        rst       = 1'b1;
        rd_addr   = '0;
        wr_addr   = '0;
        wr_data   = '0;
        busy_addr = '0;
        idle();
        tick();
        rst = 1'b0;

        // ---------------- Reset ----------------
        for (int i = 0; i < 32; i++) begin
            do_write(5'(i), {VLEN{1'b1}}, {BEW{1'b1}}, 1'b0);
        end
        busy_set = 1'b1; busy_addr = 5'd4;
        rd_en = 3'b100; rd_addr = {5'd2, 5'd0, 5'd0};
        tick();
        idle();
        check("pre_rst_busy", VLEN'(busy), VLEN'(32'h0000_0010));
        check("pre_rst_port2", port(2), {VLEN{1'b1}});

        // Inputs active during reset must be ignored.
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = {16{8'hAB}}; wr_be = '1;
        busy_set = 1'b1; busy_addr = 5'd6;
        rd_en = 3'b111;
        tick();
        rst = 1'b0;
        idle();
        check("rst_busy", VLEN'(busy), '0);
        check("rst_v0_mask", v0_mask, '0);
        check("rst_port2", port(2), '0);
        rd_en = 3'b011; rd_addr = {5'd0, 5'd0, 5'd5};
        tick();
        idle();
        check("rst_read_v5", port(0), '0);
        check("rst_read_v0", port(1), '0);

        // ---------------- Byte write ----------------
        do_write(5'd3, '0, {BEW{1'b1}}, 1'b0);
        do_write(5'd3, 128'h112233445566778899AABBCCDDEEFF11, 16'h0003, 1'b0);
        rd_en = 3'b001; rd_addr = {5'd0, 5'd0, 5'd3};
        tick();
        idle();
        check("byte_write_v3", port(0), 128'h0000_0000_0000_0000_0000_0000_0000_FF11);

        // ---------------- Register 0 ----------------
        do_write(5'd0, {16{8'hA5}}, {BEW{1'b1}}, 1'b0);
        check("v0_mask", v0_mask, {16{8'hA5}});
        rd_en = 3'b100; rd_addr = {5'd0, 5'd0, 5'd0};
        tick();
        idle();
        check("v0_read_p2", port(2), {16{8'hA5}});

        // ---------------- Collision ----------------
        do_write(5'd7, {16{8'h33}}, {BEW{1'b1}}, 1'b0);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = {16{8'hEE}}; wr_be = 16'h00FF;
        rd_en = 3'b001; rd_addr = {5'd0, 5'd0, 5'd7};
        tick();
        idle();
`ifdef VREG_BYPASS_EN
        exp_v = {{8{8'h33}}, {8{8'hEE}}};
`else
        exp_v = {16{8'h33}};
`endif
        check("collision_p0", port(0), exp_v);
        rd_en = 3'b001;
        tick();
        idle();
        check("after_collision_v7", port(0), {{8{8'h33}}, {8{8'hEE}}});

        // ---------------- Scoreboard ----------------
        busy_set = 1'b1; busy_addr = 5'd9;
        tick();
        idle();
        check("busy_set_v9", VLEN'(busy), VLEN'(32'h0000_0200));
        do_write(5'd9, {16{8'h01}}, {BEW{1'b1}}, 1'b0);
        check("busy_partial_v9", VLEN'(busy), VLEN'(32'h0000_0200));
        do_write(5'd9, {16{8'h02}}, {BEW{1'b1}}, 1'b1);
        check("busy_final_v9", VLEN'(busy), '0);
        busy_set = 1'b1; busy_addr = 5'd9;
        do_write(5'd9, {16{8'h03}}, {BEW{1'b1}}, 1'b1);
        check("busy_set_wins", VLEN'(busy), VLEN'(32'h0000_0200));
        busy_set = 1'b1; busy_addr = 5'd10;
        do_write(5'd9, {16{8'h04}}, {BEW{1'b1}}, 1'b1);
        check("busy_set_clr_diff", VLEN'(busy), VLEN'(32'h0000_0400));
        // Zero byte enables: data untouched, busy still cleared.
        do_write(5'd10, {16{8'hFF}}, '0, 1'b1);
        check("busy_be0_clear", VLEN'(busy), '0);
        rd_en = 3'b011; rd_addr = {5'd0, 5'd9, 5'd10};
        tick();
        idle();
        check("be0_no_data", port(0), '0);
        check("v9_last_write", port(1), {16{8'h04}});

        // ---------------- Multi-port ----------------
        do_write(5'd1, 128'h0123456789ABCDEF_FEDCBA9876543210, {BEW{1'b1}}, 1'b0);
        do_write(5'd31, 128'hDEADBEEF_00000000_CAFEF00D_13579BDF, {BEW{1'b1}}, 1'b0);
        rd_en = 3'b111; rd_addr = {5'd31, 5'd1, 5'd1};
        tick();
        idle();
        check("mp_p0_v1", port(0), 128'h0123456789ABCDEF_FEDCBA9876543210);
        check("mp_p1_v1", port(1), 128'h0123456789ABCDEF_FEDCBA9876543210);
        check("mp_p2_v31", port(2), 128'hDEADBEEF_00000000_CAFEF00D_13579BDF);
        rd_en = 3'b101; rd_addr = {5'd3, 5'd31, 5'd31};
        tick();
        idle();
        check("mp_p1_hold", port(1), 128'h0123456789ABCDEF_FEDCBA9876543210);
        check("mp_p0_v31", port(0), 128'hDEADBEEF_00000000_CAFEF00D_13579BDF);
        check("mp_p2_v3", port(2), 128'h0000_0000_0000_0000_0000_0000_0000_FF11);
        check("v0_mask_final", v0_mask, {16{8'hA5}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vreg_file

// File: doc/vreg_file.md
# vreg_file

Parametrised vector register file for the RVV datapath: 32 architectural registers of VLEN bits, NRD registered read ports, one byte-enabled write port, and a per-register busy scoreboard. It sits between decode/issue (read operands, mark destinations pending) and the vector execution/writeback pipeline (partial and final writes). Unlike the scalar register file, register 0 is an ordinary writable register, reads are synchronous, and writes are byte-granular.

## Interface
- VLEN, 128: bits per vector register; multiple of 8, minimum 32.
- NRD, 3: number of read ports (vs1, vs2, vd/old-value), minimum 1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  NRD  per-port read strobe.
- rd_addr  in  NRD*5  per-port register index; port p uses bits [5p+4:5p].
- rd_data  out  NRD*VLEN  per-port registered read data; port p uses bits [VLEN*p+VLEN-1:VLEN*p].
- wr_en  in  1  write strobe.
- wr_addr  in  5  write register index.
- wr_data  in  VLEN  write data.
- wr_be  in  VLEN/8  byte enables; bit b covers wr_data[8b+7:8b].
- wr_last  in  1  final write of the instruction; clears busy for wr_addr.
- busy_set  in  1  issue marks a destination pending.
- busy_addr  in  5  register to mark.
- busy  out  32  per-register pending flags.
- v0_mask  out  VLEN  combinational copy of register 0 for mask consumers.

## Operation
- Reset (rst high at a clock edge): all 32 registers, rd_data, and busy become 0. Inputs are ignored on that edge. v0_mask is 0 from the following cycle.
- Write: when wr_en is high, each byte b of register wr_addr with wr_be[b]=1 takes wr_data byte b. Other bytes are unchanged. All 32 indices are writable, including 0.
- Read: when rd_en[p] is high, rd_data port p captures register rd_addr[p] at the edge. When rd_en[p] is low, port p holds its previous value.
- Several ports may read the same index. Each port returns the same data.
- Scoreboard: busy_set sets busy[busy_addr]. When wr_en and wr_last are both high, busy[wr_addr] is cleared.
- If the set and the clear target the same index on the same edge, set wins.
- If the set and the clear target different indices on the same edge, both take effect.
- wr_en with wr_be all zero changes no data. If wr_last is also high, busy is still cleared.
- Writing a register whose busy flag is 0 is legal. The scoreboard only records pending state and never blocks writes.
- Read/write collision (same index, same edge) is controlled by the bypass macro; see Configuration.

## Timing
- Read latency: 1 cycle. rd_data port p is valid in the cycle after rd_en[p] is high.
- Write: visible to reads issued on the next edge. Same-edge visibility depends on the bypass macro.
- busy: updates on the clock edge; visible the cycle after busy_set or the final write.
- v0_mask: combinational from storage; reflects a write to register 0 in the cycle after that write.
- No handshake: all ports accept one operation per cycle, with no back-pressure.

## Configuration
- VREG_BYPASS_EN defined: a read and a write to the same index on the same edge return the merged value. Bytes with wr_be=1 come from wr_data; the remaining bytes come from stored data.
- VREG_BYPASS_EN undefined: the same collision returns the pre-write stored value. This saves the forwarding muxes.
- The scoreboard and v0_mask behave identically in both builds.

## Structure
- Package vreg_pkg holds:
  - VREG_NUM = 32
  - VREG_AW = 5
  - a function returning the byte-enable width from VLEN
- Sub-module vreg_scoreboard holds the 32-bit busy register and the set/clear/priority logic. Ports: clk, rst, busy_set, busy_addr, clr_en, clr_addr, busy.
- Storage, write-merge logic and read ports live in vreg_file.

## Test plan
- Reset: write 0xFF..FF to all registers, assert rst for 1 cycle, then read v5 and v0 → rd_data = 0, busy = 0, v0_mask = 0.
- Byte write: write v3 = 0 (all be), then wr_data = 0x1122..FF with wr_be = 0x0003, then read v3 → only bytes 0–1 updated, all other bytes 0.
- Register 0: write v0 = 0xA5A5..A5 → v0_mask = 0xA5A5..A5 one cycle later, and a read of v0 on port 2 returns the same value.
- Collision, same edge: write v7 with wr_be = 0x00FF while port 0 reads v7 →
  - with VREG_BYPASS_EN: the low 8 bytes come from the new data;
  - without it: the old value is returned.
- Scoreboard: busy_set on v9 → busy[9] = 1. A write to v9 with wr_last = 0 leaves busy[9] = 1. A write with wr_last = 1 clears it. Simultaneous busy_set on v9 and a final write to v9 → busy[9] stays 1.
- Multi-port: ports 0/1/2 read v1/v1/v31 in one cycle, with rd_en on port 1 dropped the next cycle → ports 0 and 1 are equal, and port 1 holds its value.
